// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Definitions shared by the stack-architecture CPU blocks:
//   - default data width and operand-stack depth
//   - instruction opcodes (PUSH..RET), decoded by the control FSM
//   - control FSM state encodings, so that datapath blocks and benches
//     can name the states the controller steps through
//   The package has no ports.
package cpu_pkg;

  // Width of one memory word / stack entry and default operand-stack depth
  localparam int CPU_DATA_WIDTH = 16;
  localparam int STACK_DEPTH    = 32;

  // Instruction opcodes
  typedef enum logic [3:0] {
    OP_PUSH  = 4'h0,
    OP_POP   = 4'h1,
    OP_ADD   = 4'h2,
    OP_SUB   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_NOT   = 4'h6,
    OP_LOAD  = 4'h7,
    OP_STORE = 4'h8,
    OP_JMP   = 4'h9,
    OP_JZ    = 4'hA,
    OP_CALL  = 4'hB,
    OP_RET   = 4'hC
  } opcode_e;

  // Control FSM states. SET_A issues a pop; SAVE_A captures pop_data one
  // clock later, which is why the stack registers its pop result.
  typedef enum logic [3:0] {
    ST_FETCH   = 4'h0,
    ST_DECODE  = 4'h1,
    ST_SET_A   = 4'h2,
    ST_SAVE_A  = 4'h3,
    ST_SET_B   = 4'h4,
    ST_SAVE_B  = 4'h5,
    ST_EXECUTE = 4'h6,
    ST_PUSH    = 4'h7,
    ST_MEM     = 4'h8,
    ST_BRANCH  = 4'h9
  } ctrl_state_e;

  // True when the opcode consumes two operands from the stack
  function automatic logic is_binary_op(input opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/stack_ram.sv
// stack_ram
//   Storage array of the operand stack: DEPTH x DATA_WIDTH words with one
//   synchronous write port and one asynchronous read port. The contents
//   are deliberately not reset.
// Ports
//   clk    in   rising-edge clock for the write port
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address (combinational read)
//   rdata  out  mem[raddr]
module stack_ram
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = CPU_DATA_WIDTH,
  parameter int DEPTH      = STACK_DEPTH,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Single write port; no reset so the array maps onto plain RAM
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read, no write-through bypass
  assign rdata = mem[raddr];

endmodule

// File: rtl/data_stack.sv
// data_stack
//   Hardware LIFO for the CPU operand stack. Holds the stack pointer, the
//   registered pop result and the fault flags; storage lives in stack_ram.
//   Build option: define DATA_STACK_ERR_STICKY_EN to make err_ovf/err_unf
//   sticky (cleared only by rst_n or rst_stack). Without it they are
//   single-cycle pulses, high the cycle after the offending request.
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous reset, active-low
//   rst_stack   in   synchronous clear from control (beats push/pop)
//   push_stack  in   push stack_data
//   pop_stack   in   pop top entry (with push_stack: replace top)
//   stack_data  in   value to push
//   pop_data    out  value of last successful pop, one clock after the pop
//   pop_valid   out  pulse: pop_data updated this cycle
//   top_data    out  mem[sp-1], 0 when empty
//   sp          out  number of entries held, 0..DEPTH
//   empty       out  sp == 0
//   full        out  sp == DEPTH
//   err_ovf     out  push refused because full
//   err_unf     out  pop refused because empty
module data_stack
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = CPU_DATA_WIDTH,
  parameter int DEPTH      = STACK_DEPTH,
  localparam int PTR_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rst_stack,
  input  logic                  push_stack,
  input  logic                  pop_stack,
  input  logic [DATA_WIDTH-1:0] stack_data,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] top_data,
  output logic [PTR_W-1:0]      sp,
  output logic                  empty,
  output logic                  full,
  output logic                  err_ovf,
  output logic                  err_unf
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0]     top_addr;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  ram_we;
  logic [PTR_W-1:0]      sp_next;
  logic                  pop_take;
  logic                  ovf_event;
  logic                  unf_event;

  assign empty = (sp == '0);
  assign full  = (sp == PTR_W'(DEPTH));

  // Address of the current top entry. When sp == DEPTH the low bits are
  // zero and the subtraction wraps to DEPTH-1, which is what we want.
  assign top_addr = sp[ADDR_W-1:0] - ADDR_W'(1);

  stack_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (stack_data),
    .raddr (top_addr),
    .rdata (rd_data)
  );

  assign top_data = empty ? '0 : rd_data;

  // Decode the request into a RAM write, the next pointer and fault events.
  // Push+pop on a non-empty stack overwrites the top in place while the old
  // top is captured into pop_data. On an empty stack it degrades to a plain
  // push and still flags the underflow. rst_stack suppresses the write.
  always_comb begin
    ram_we    = 1'b0;
    wr_addr   = sp[ADDR_W-1:0];
    sp_next   = sp;
    pop_take  = 1'b0;
    ovf_event = 1'b0;
    unf_event = 1'b0;
    if (push_stack && pop_stack) begin
      if (empty) begin
        ram_we    = 1'b1;
        sp_next   = sp + PTR_W'(1);
        unf_event = 1'b1;
      end else begin
        ram_we   = 1'b1;
        wr_addr  = top_addr;
        pop_take = 1'b1;
      end
    end else if (push_stack) begin
      if (full) begin
        ovf_event = 1'b1;
      end else begin
        ram_we  = 1'b1;
        sp_next = sp + PTR_W'(1);
      end
    end else if (pop_stack) begin
      if (empty) begin
        unf_event = 1'b1;
      end else begin
        pop_take = 1'b1;
        sp_next  = sp - PTR_W'(1);
      end
    end
    if (rst_stack) begin
      ram_we = 1'b0;
    end
  end

  // Pointer, pop result and fault flags. pop_data is left alone by
  // rst_stack; only a successful pop or rst_n changes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp        <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
    end else if (rst_stack) begin
      sp        <= '0;
      pop_valid <= 1'b0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
    end else begin
      sp        <= sp_next;
      pop_valid <= pop_take;
      if (pop_take) begin
        pop_data <= rd_data;
      end
`ifdef DATA_STACK_ERR_STICKY_EN
      err_ovf <= err_ovf | ovf_event;
      err_unf <= err_unf | unf_event;
`else
      err_ovf <= ovf_event;
      err_unf <= unf_event;
`endif
    end
  end

endmodule

// File: tb/tb_data_stack.sv
// tb_data_stack
//   Directed bench for data_stack with a queue-based reference model that
//   is compared against the DUT on every falling clock edge, plus literal
//   expectations at the key points of each scenario.
module tb_data_stack;

  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic            clk;
  logic            rst_n;
  logic            rst_stack;
  logic            push_stack;
  logic            pop_stack;
  logic [DW-1:0]   stack_data;
  logic [DW-1:0]   pop_data;
  logic            pop_valid;
  logic [DW-1:0]   top_data;
  logic [PTR_W-1:0] sp;
  logic            empty;
  logic            full;
  logic            err_ovf;
  logic            err_unf;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  bit sticky;

  data_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_stack  (rst_stack),
    .push_stack (push_stack),
    .pop_stack  (pop_stack),
    .stack_data (stack_data),
    .pop_data   (pop_data),
    .pop_valid  (pop_valid),
    .top_data   (top_data),
    .sp         (sp),
    .empty      (empty),
    .full       (full),
    .err_ovf    (err_ovf),
    .err_unf    (err_unf)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the stack is a queue, faults follow the build option
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_pop_data  = '0;
  logic          m_pop_valid = 1'b0;
  logic          m_ovf       = 1'b0;
  logic          m_unf       = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit ovf_ev;
    bit unf_ev;
    if (!rst_n) begin
      m_q.delete();
      m_pop_data  = '0;
      m_pop_valid = 1'b0;
      m_ovf       = 1'b0;
      m_unf       = 1'b0;
    end else if (rst_stack) begin
      m_q.delete();
      m_pop_valid = 1'b0;
      m_ovf       = 1'b0;
      m_unf       = 1'b0;
    end else begin
      ovf_ev      = 1'b0;
      unf_ev      = 1'b0;
      m_pop_valid = 1'b0;
      if (push_stack && pop_stack) begin
        if (m_q.size() == 0) begin
          m_q.push_back(stack_data);
          unf_ev = 1'b1;
        end else begin
          m_pop_data = m_q[m_q.size()-1];
          m_q[m_q.size()-1] = stack_data;
          m_pop_valid = 1'b1;
        end
      end else if (push_stack) begin
        if (m_q.size() == DEPTH) ovf_ev = 1'b1;
        else m_q.push_back(stack_data);
      end else if (pop_stack) begin
        if (m_q.size() == 0) unf_ev = 1'b1;
        else begin
          m_pop_data  = m_q.pop_back();
          m_pop_valid = 1'b1;
        end
      end
      if (sticky) begin
        m_ovf = m_ovf | ovf_ev;
        m_unf = m_unf | unf_ev;
      end else begin
        m_ovf = ovf_ev;
        m_unf = unf_ev;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("sp",        32'(sp),        32'(m_q.size()));
      checkOutput("empty",     32'(empty),     32'(m_q.size() == 0));
      checkOutput("full",      32'(full),      32'(m_q.size() == DEPTH));
      checkOutput("top_data",  32'(top_data),  (m_q.size() == 0) ? 32'd0 : 32'(m_q[m_q.size()-1]));
      checkOutput("pop_data",  32'(pop_data),  32'(m_pop_data));
      checkOutput("pop_valid", 32'(pop_valid), 32'(m_pop_valid));
      checkOutput("err_ovf",   32'(err_ovf),   32'(m_ovf));
      checkOutput("err_unf",   32'(err_unf),   32'(m_unf));
    end
  end

  // Drive one cycle of requests, then return just after the active edge
  task automatic applyStimulus(input logic p_push, input logic p_pop,
                               input logic p_rst, input logic [DW-1:0] p_data);
    push_stack = p_push;
    pop_stack  = p_pop;
    rst_stack  = p_rst;
    stack_data = p_data;
    @(posedge clk);
    #1;
    push_stack = 1'b0;
    pop_stack  = 1'b0;
    rst_stack  = 1'b0;
    stack_data = '0;
  endtask

  initial begin
`ifdef DATA_STACK_ERR_STICKY_EN
    sticky = 1'b1;
`else
    sticky = 1'b0;
`endif
    rst_n      = 1'b1;
    rst_stack  = 1'b0;
    push_stack = 1'b0;
    pop_stack  = 1'b0;
    stack_data = '0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset sp",        32'(sp),        32'd0);
    checkOutput("reset pop_valid", 32'(pop_valid), 32'd0);
    checkOutput("reset pop_data",  32'(pop_data),  32'd0);
    checkOutput("reset errors",    32'({err_ovf, err_unf}), 32'd0);
    checkOutput("reset empty",     32'(empty),     32'd1);
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Scenario 1: three pushes
    applyStimulus(1, 0, 0, 16'h0011);
    applyStimulus(1, 0, 0, 16'h0022);
    applyStimulus(1, 0, 0, 16'h0033);
    checkOutput("s1 sp",    32'(sp),       32'd3);
    checkOutput("s1 top",   32'(top_data), 32'h0033);
    checkOutput("s1 empty", 32'(empty),    32'd0);

    // Scenario 2: pop three, LIFO order, one clock latency
    applyStimulus(0, 1, 0, '0);
    checkOutput("s2 pop0",   32'(pop_data),  32'h0033);
    checkOutput("s2 valid0", 32'(pop_valid), 32'd1);
    applyStimulus(0, 1, 0, '0);
    checkOutput("s2 pop1",   32'(pop_data),  32'h0022);
    applyStimulus(0, 1, 0, '0);
    checkOutput("s2 pop2",   32'(pop_data),  32'h0011);
    checkOutput("s2 sp",     32'(sp),        32'd0);
    checkOutput("s2 empty",  32'(empty),     32'd1);
    checkOutput("s2 top",    32'(top_data),  32'd0);
    applyStimulus(0, 0, 0, '0);
    checkOutput("s2 valid idle", 32'(pop_valid), 32'd0);

    // Scenario 3: underflow
    applyStimulus(0, 1, 0, '0);
    checkOutput("s3 sp",       32'(sp),        32'd0);
    checkOutput("s3 pop_data", 32'(pop_data),  32'h0011);
    checkOutput("s3 valid",    32'(pop_valid), 32'd0);
    checkOutput("s3 err_unf",  32'(err_unf),   32'd1);
    applyStimulus(0, 0, 0, '0);
    checkOutput("s3 err_unf after", 32'(err_unf), sticky ? 32'd1 : 32'd0);

    // Scenario 4: fill to DEPTH then overflow
    applyStimulus(0, 0, 1, '0);
    checkOutput("s4 clear err_unf", 32'(err_unf), 32'd0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, 16'(16'h0100 + i));
    checkOutput("s4 full pre", 32'(full), 32'd1);
    applyStimulus(1, 0, 0, 16'hBEEF);
    checkOutput("s4 full",    32'(full),     32'd1);
    checkOutput("s4 sp",      32'(sp),       32'd32);
    checkOutput("s4 top",     32'(top_data), 32'h011F);
    checkOutput("s4 err_ovf", 32'(err_ovf),  32'd1);
    applyStimulus(0, 1, 0, '0);
    checkOutput("s4 pop top", 32'(pop_data), 32'h011F);
    checkOutput("s4 err_ovf after", 32'(err_ovf), sticky ? 32'd1 : 32'd0);

    // Scenario 5: replace top
    applyStimulus(0, 0, 1, '0);
    applyStimulus(1, 0, 0, 16'h0003);
    applyStimulus(1, 0, 0, 16'h0005);
    applyStimulus(1, 1, 0, 16'h0009);
    checkOutput("s5 pop_data", 32'(pop_data),  32'h0005);
    checkOutput("s5 valid",    32'(pop_valid), 32'd1);
    checkOutput("s5 top",      32'(top_data),  32'h0009);
    checkOutput("s5 sp",       32'(sp),        32'd2);
    applyStimulus(0, 1, 0, '0);
    applyStimulus(0, 1, 0, '0);
    checkOutput("s5 bottom", 32'(pop_data), 32'h0003);

    // Push+pop on empty acts as a push plus underflow
    applyStimulus(1, 1, 0, 16'h00AA);
    checkOutput("s5e sp",      32'(sp),        32'd1);
    checkOutput("s5e top",     32'(top_data),  32'h00AA);
    checkOutput("s5e valid",   32'(pop_valid), 32'd0);
    checkOutput("s5e err_unf", 32'(err_unf),   32'd1);

    // Scenario 6: rst_stack with a push at sp=5, then rst_n during a pop
    applyStimulus(0, 0, 1, '0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 16'(16'h0A00 + i));
    applyStimulus(0, 1, 0, '0);
    applyStimulus(1, 0, 0, 16'h0A55);
    checkOutput("s6 sp pre", 32'(sp), 32'd5);
    applyStimulus(1, 0, 1, 16'h7777);
    checkOutput("s6 sp",     32'(sp),        32'd0);
    checkOutput("s6 empty",  32'(empty),     32'd1);
    checkOutput("s6 valid",  32'(pop_valid), 32'd0);
    checkOutput("s6 errors", 32'({err_ovf, err_unf}), 32'd0);
    applyStimulus(1, 0, 0, 16'h1234);
    applyStimulus(1, 0, 0, 16'h5678);
    pop_stack = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s6 async sp",    32'(sp),        32'd0);
    checkOutput("s6 async valid", 32'(pop_valid), 32'd0);
    checkOutput("s6 async data",  32'(pop_data),  32'd0);
    @(posedge clk); #1;
    pop_stack = 1'b0;
    rst_n = 1'b1;
    checkOutput("s6 held in reset", 32'(pop_valid), 32'd0);
    applyStimulus(1, 0, 0, 16'h4321);
    checkOutput("s6 after reset top", 32'(top_data), 32'h4321);
    applyStimulus(0, 0, 0, '0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
